// File: rtl/vproc_fpu_fflags_acc.sv
// Sticky per-instruction accumulator of fpnew exception flags across vector FPU result beats,
// with a small FIFO of completed fflags updates feeding the scalar core's CSR write port.
module vproc_fpu_fflags_acc #(
  parameter int unsigned FPU_OP_W   = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      async_rst_ni,
  input  logic                      flush_i,

  input  logic                      res_valid_i,
  output logic                      res_ready_o,
  input  logic [FPU_OP_W/32*5-1:0]  res_status_i,
  input  logic [FPU_OP_W/8-1:0]     res_mask_i,
  input  logic                      res_last_i,

  output logic                      fflags_valid_o,
  input  logic                      fflags_ready_i,
  output logic [4:0]                fflags_o,
  output logic                      busy_o
);

  localparam int unsigned LANES  = FPU_OP_W / 32;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FLAG_W-1:0] acc_q, acc_d;
  logic              in_instr_q, in_instr_d;
  logic [FLAG_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [FLAG_W-1:0] beat_flags;
  logic [FLAG_W-1:0] fin;
  logic              fifo_full, fifo_empty;
  logic              accept, push, pop;

  // OR the status of every lane that has at least one enabled byte
  always_comb begin
    beat_flags = '0;
    for (int unsigned g = 0; g < LANES; g++) begin
      if (|res_mask_i[4*g +: 4]) begin
        beat_flags = beat_flags | res_status_i[FLAG_W*g +: FLAG_W];
      end
    end
  end

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // All handshake outputs come from registered state only
  assign res_ready_o    = !fifo_full;
  assign fflags_valid_o = !fifo_empty;
  assign fflags_o       = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign busy_o         = in_instr_q | !fifo_empty;

  assign accept = res_valid_i & res_ready_o;
  assign fin    = acc_q | beat_flags;
  assign push   = accept & res_last_i & (fin != '0);
  assign pop    = fflags_valid_o & fflags_ready_i;

  always_comb begin
    acc_d      = acc_q;
    in_instr_d = in_instr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (flush_i) begin
      acc_d      = '0;
      in_instr_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept) begin
        if (res_last_i) begin
          acc_d      = '0;
          in_instr_d = 1'b0;
        end else begin
          acc_d      = fin;
          in_instr_d = 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      acc_q      <= '0;
      in_instr_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      acc_q      <= acc_d;
      in_instr_q <= in_instr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; stale contents are never visible because fflags_o is gated by fifo_empty
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push && !flush_i) begin
      fifo_q[wr_ptr_q] <= fin;
    end
  end

endmodule

// File: tb/tb_vproc_fpu_fflags_acc.sv
// Self-checking bench for vproc_fpu_fflags_acc: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_vproc_fpu_fflags_acc;

  localparam int unsigned FPU_OP_W   = 64;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned LANES      = FPU_OP_W / 32;
  localparam int unsigned ST_W       = LANES * 5;
  localparam int unsigned MK_W       = FPU_OP_W / 8;

  logic            clk_i = 1'b0;
  logic            async_rst_ni;
  logic            flush_i;
  logic            res_valid_i;
  logic            res_ready_o;
  logic [ST_W-1:0] res_status_i;
  logic [MK_W-1:0] res_mask_i;
  logic            res_last_i;
  logic            fflags_valid_o;
  logic            fflags_ready_i;
  logic [4:0]      fflags_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_q[$];
  logic [4:0] m_acc;
  bit         m_in;

  vproc_fpu_fflags_acc #(.FPU_OP_W(FPU_OP_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i          (clk_i),
    .async_rst_ni   (async_rst_ni),
    .flush_i        (flush_i),
    .res_valid_i    (res_valid_i),
    .res_ready_o    (res_ready_o),
    .res_status_i   (res_status_i),
    .res_mask_i     (res_mask_i),
    .res_last_i     (res_last_i),
    .fflags_valid_o (fflags_valid_o),
    .fflags_ready_i (fflags_ready_i),
    .fflags_o       (fflags_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] lane_or(input logic [ST_W-1:0] st, input logic [MK_W-1:0] mk);
    logic [4:0] r = '0;
    for (int g = 0; g < LANES; g++) begin
      if (mk[4*g +: 4] != 0) r |= st[5*g +: 5];
    end
    return r;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_acc = '0;
    m_in  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("res_ready", 32'(res_ready_o), 32'(m_q.size() < FIFO_DEPTH));
    chk("fflags_valid", 32'(fflags_valid_o), 32'(m_q.size() != 0));
    chk("fflags", 32'(fflags_o), 32'((m_q.size() != 0) ? m_q[0] : 5'd0));
    chk("busy", 32'(busy_o), 32'(m_in || (m_q.size() != 0)));
  endtask

  // One clock: check outputs at negedge, drive inputs, advance model, return at posedge
  task automatic cycle(input logic v, input logic [ST_W-1:0] st, input logic [MK_W-1:0] mk,
                       input logic l, input logic fr, input logic fl);
    logic [4:0] fin;
    bit acc_ok, pop_ok;
    @(negedge clk_i);
    check_outputs();
    res_valid_i    = v;
    res_status_i   = st;
    res_mask_i     = mk;
    res_last_i     = l;
    fflags_ready_i = fr;
    flush_i        = fl;
    if (fl) begin
      model_clear();
    end else begin
      acc_ok = v && (m_q.size() < FIFO_DEPTH);
      pop_ok = fr && (m_q.size() != 0);
      if (pop_ok) void'(m_q.pop_front());
      if (acc_ok) begin
        fin = m_acc | lane_or(st, mk);
        if (l) begin
          m_acc = '0;
          m_in  = 1'b0;
          if (fin != 0) m_q.push_back(fin);
        end else begin
          m_acc = fin;
          m_in  = 1'b1;
        end
      end
    end
    @(posedge clk_i);
  endtask

  task automatic idle(input logic fr);
    cycle(1'b0, '0, '0, 1'b0, fr, 1'b0);
  endtask

  initial begin
    async_rst_ni   = 1'b0;
    flush_i        = 1'b0;
    res_valid_i    = 1'b0;
    res_status_i   = '0;
    res_mask_i     = '0;
    res_last_i     = 1'b0;
    fflags_ready_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_ready", 32'(res_ready_o), 32'd1);
    chk("rst_valid", 32'(fflags_valid_o), 32'd0);
    chk("rst_fflags", 32'(fflags_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    async_rst_ni = 1'b1;

    // Two lanes, full mask: lane0 NX, lane1 NV
    cycle(1'b1, {5'b10000, 5'b00001}, 8'hFF, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t1_valid", 32'(fflags_valid_o), 32'd1);
    chk("t1_fflags", 32'(fflags_o), 32'h11);
    idle(1'b1);

    // Upper lane masked off: its NV must be ignored
    cycle(1'b1, {5'b10000, 5'b00001}, 8'h0F, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t2_fflags", 32'(fflags_o), 32'h01);
    idle(1'b1);
    idle(1'b0);

    // Three beats NX, OF, DZ -> one update 01101
    cycle(1'b1, {5'b00000, 5'b00001}, 8'hFF, 1'b0, 1'b0, 1'b0);
    #2;
    chk("t3_busy_b1", 32'(busy_o), 32'd1);
    cycle(1'b1, {5'b00100, 5'b00000}, 8'hF0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {5'b00000, 5'b01000}, 8'h01, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t3_fflags", 32'(fflags_o), 32'h0D);
    chk("t3_busy_q", 32'(busy_o), 32'd1);
    idle(1'b0);
    idle(1'b1);
    #2;
    chk("t3_busy_pop", 32'(busy_o), 32'd0);
    chk("t3_valid_pop", 32'(fflags_valid_o), 32'd0);

    // Back-pressure: three updates with the CSR port stalled
    cycle(1'b1, {5'b00000, 5'b00001}, 8'hFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, {5'b00000, 5'b00010}, 8'hFF, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t4_ready_full", 32'(res_ready_o), 32'd0);
    cycle(1'b1, {5'b00000, 5'b00100}, 8'hFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, {5'b00000, 5'b00100}, 8'hFF, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t4_head_held", 32'(fflags_o), 32'h01);
    cycle(1'b1, {5'b00000, 5'b00100}, 8'hFF, 1'b1, 1'b1, 1'b0);
    #2;
    chk("t4_second", 32'(fflags_o), 32'h02);
    cycle(1'b1, {5'b00000, 5'b00100}, 8'hFF, 1'b1, 1'b1, 1'b0);
    #2;
    chk("t4_third", 32'(fflags_o), 32'h04);
    idle(1'b1);
    idle(1'b0);

    // All-zero status: nothing queued, busy drops after last beat
    cycle(1'b1, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, '0, 8'hFF, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t5_valid", 32'(fflags_valid_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);

    // Flush mid-instruction with one entry queued
    cycle(1'b1, {5'b00000, 5'b00001}, 8'hFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, {5'b10000, 5'b00000}, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, {5'b00010, 5'b00000}, 8'hFF, 1'b1, 1'b1, 1'b1);
    #2;
    chk("t6_fl_valid", 32'(fflags_valid_o), 32'd0);
    chk("t6_fl_busy", 32'(busy_o), 32'd0);
    chk("t6_fl_ready", 32'(res_ready_o), 32'd1);
    cycle(1'b1, {5'b00000, 5'b00010}, 8'hFF, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t6_fl_fresh", 32'(fflags_o), 32'h02);

    // Async reset mid-instruction with one entry queued
    cycle(1'b1, {5'b01000, 5'b00000}, 8'hFF, 1'b0, 1'b0, 1'b0);
    res_valid_i = 1'b0;
    #2;
    async_rst_ni = 1'b0;
    #1;
    model_clear();
    chk("t6_rst_valid", 32'(fflags_valid_o), 32'd0);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_ready", 32'(res_ready_o), 32'd1);
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    cycle(1'b1, {5'b00000, 5'b00001}, 8'hFF, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t6_rst_fresh", 32'(fflags_o), 32'h01);
    idle(1'b1);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [ST_W-1:0] st;
      logic [MK_W-1:0] mk;
      st = ($urandom_range(0, 2) == 0) ? ST_W'($urandom) : '0;
      case ($urandom_range(0, 3))
        0:       mk = '0;
        1:       mk = MK_W'($urandom_range(1, 15));
        2:       mk = MK_W'($urandom_range(1, 15) << 4);
        default: mk = MK_W'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), st, mk, ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end
    idle(1'b1);
    idle(1'b1);
    @(negedge clk_i);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
